// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encoding, default protocol timing
// and the nanosecond-to-clock-cycle conversion used by both rx and driver.
`timescale 1ns/1ps
package ws2812_pkg;

    localparam int WS_SYSTEM_CLOCK = 50_000_000;
    localparam int WS_T_BIT_NS     = 625;
    localparam int WS_T_MIN_HIGH_NS = 100;
    localparam int WS_T_MAX_HIGH_NS = 2000;
    localparam int WS_T_RESET_NS   = 50_000;
    localparam int WS_WORD_BITS    = 24;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_e;

    // Integer MHz first so the intermediate product stays within 32 bits.
    function automatic int ns_to_cycles(input int t_ns, input int clk_hz);
        return (t_ns * (clk_hz / 1_000_000)) / 1000;
    endfunction

endpackage

// File: rtl/ws2812_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
`timescale 1ns/1ps
module sync_2ff (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Metastability filter chain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: measures high/low pulse widths on DIN and assembles
// MSB-first 24-bit GRB words, tagging each with its LED index in the frame.
`timescale 1ns/1ps
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS      = 8,
    parameter int SYSTEM_CLOCK  = WS_SYSTEM_CLOCK,
    parameter int T_BIT_NS      = WS_T_BIT_NS,
    parameter int T_MIN_HIGH_NS = WS_T_MIN_HIGH_NS,
    parameter int T_MAX_HIGH_NS = WS_T_MAX_HIGH_NS,
    parameter int T_RESET_NS    = WS_T_RESET_NS
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          DIN,
    output logic [23:0]                   DATA,
    output logic [$clog2(NUM_LEDS)-1:0]   ADDR,
    output logic                          VALID,
    output logic                          FRAME_DONE,
    output logic [$clog2(NUM_LEDS):0]     LED_COUNT,
    output logic                          ERR
);

    localparam int BIT_CYC   = ns_to_cycles(T_BIT_NS, SYSTEM_CLOCK);
    localparam int MIN_CYC   = ns_to_cycles(T_MIN_HIGH_NS, SYSTEM_CLOCK);
    localparam int MAX_CYC   = ns_to_cycles(T_MAX_HIGH_NS, SYSTEM_CLOCK);
    localparam int RESET_CYC = ns_to_cycles(T_RESET_NS, SYSTEM_CLOCK);
    localparam int CNT_W     = $clog2(RESET_CYC + 1);
    localparam int AW        = $clog2(NUM_LEDS);
    localparam int CW        = AW + 1;

    localparam logic [CNT_W-1:0] BIT_C  = CNT_W'(BIT_CYC);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] HSAT_C = CNT_W'(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] RST_C  = CNT_W'(RESET_CYC);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CW-1:0]    NUM_C  = CW'(NUM_LEDS);

    logic             din_s;
    logic             din_prev_q;
    logic             rise_s;
    logic             fall_s;
    state_e           state_q;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] low_cnt_q;
    logic [CNT_W-1:0] high_cnt_d;
    logic [CNT_W-1:0] low_cnt_d;
    logic             bit_d;
    logic [23:0]      shift_q;
    logic [4:0]       bit_idx_q;
    logic [CW-1:0]    led_idx_q;
    logic             word_done_q;
    logic [23:0]      data_q;
    logic [AW-1:0]    addr_q;
    logic             valid_q;
    logic             frame_done_q;
    logic [CW-1:0]    led_count_q;
    logic             err_q;

    sync_2ff u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (DIN),
        .q     (din_s)
    );

    // History flop for edge detection on the synchronised line.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            din_prev_q <= 1'b0;
        end else begin
            din_prev_q <= din_s;
        end
    end

    assign rise_s = din_s & ~din_prev_q;
    assign fall_s = ~din_s & din_prev_q;

    // Saturating counter increments and the bit decision.
    always_comb begin
        high_cnt_d = (high_cnt_q == HSAT_C) ? high_cnt_q : high_cnt_q + ONE_C;
        low_cnt_d  = (low_cnt_q == RST_C) ? low_cnt_q : low_cnt_q + ONE_C;
        bit_d      = (high_cnt_q > BIT_C);
    end

    // Receiver FSM with registered word/frame outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_SYNC;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            shift_q      <= 24'h000000;
            bit_idx_q    <= 5'd0;
            led_idx_q    <= '0;
            word_done_q  <= 1'b0;
            data_q       <= 24'h000000;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            led_count_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            word_done_q  <= 1'b0;

            // A word completed last cycle: emit it or flag overflow.
            if (word_done_q) begin
                if (led_idx_q < NUM_C) begin
                    valid_q   <= 1'b1;
                    data_q    <= shift_q;
                    addr_q    <= led_idx_q[AW-1:0];
                    led_idx_q <= led_idx_q + CW'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end

            case (state_q)
                ST_SYNC: begin
                    if (din_s) begin
                        low_cnt_q <= '0;
                    end else if (low_cnt_q == RST_C) begin
                        state_q <= ST_IDLE;
                    end else begin
                        low_cnt_q <= low_cnt_d;
                    end
                end
                ST_IDLE: begin
                    if (rise_s) begin
                        state_q    <= ST_HIGH;
                        high_cnt_q <= '0;
                        bit_idx_q  <= 5'd0;
                        led_idx_q  <= '0;
                        err_q      <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (fall_s) begin
                        low_cnt_q <= '0;
                        if (high_cnt_q < MIN_C) begin
                            err_q   <= 1'b1;
                            state_q <= ST_SYNC;
                        end else begin
                            shift_q <= {shift_q[22:0], bit_d};
                            state_q <= ST_LOW;
                            if (bit_idx_q == 5'd23) begin
                                bit_idx_q   <= 5'd0;
                                word_done_q <= 1'b1;
                            end else begin
                                bit_idx_q <= bit_idx_q + 5'd1;
                            end
                        end
                    end else if (high_cnt_q > MAX_C) begin
                        err_q     <= 1'b1;
                        low_cnt_q <= '0;
                        state_q   <= ST_SYNC;
                    end else begin
                        high_cnt_q <= high_cnt_d;
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        high_cnt_q <= '0;
                        state_q    <= ST_HIGH;
                    end else if (low_cnt_q == RST_C) begin
                        state_q      <= ST_IDLE;
                        frame_done_q <= 1'b1;
                        led_count_q  <= led_idx_q;
                        led_idx_q    <= '0;
                        bit_idx_q    <= 5'd0;
                        if (bit_idx_q != 5'd0) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        low_cnt_q <= low_cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign DATA       = data_q;
    assign ADDR       = addr_q;
    assign VALID      = valid_q;
    assign FRAME_DONE = frame_done_q;
    assign LED_COUNT  = led_count_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed/randomised bench for ws2812_rx: drives WS2812 waveforms in real time
// and compares captured words and frame status with a list-based expectation.
`timescale 1ns/1ps
module tb_ws2812_rx;

    localparam int NUM = 8;

    logic        CLK;
    logic        RST_N;
    logic        DIN;
    logic [23:0] DATA;
    logic [2:0]  ADDR;
    logic        VALID;
    logic        FRAME_DONE;
    logic [3:0]  LED_COUNT;
    logic        ERR;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] got_data[$];
    logic [2:0]  got_addr[$];
    logic [23:0] exp_q[$];
    int          fd_cnt = 0;
    time         fall_t = 0;
    time         lat = 0;

    ws2812_rx #(.NUM_LEDS(NUM)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .DIN        (DIN),
        .DATA       (DATA),
        .ADDR       (ADDR),
        .VALID      (VALID),
        .FRAME_DONE (FRAME_DONE),
        .LED_COUNT  (LED_COUNT),
        .ERR        (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    // Passive capture of output strobes, sampled 1 ns after the edge.
    always @(posedge CLK) begin
        #1;
        if (VALID === 1'b1) begin
            got_data.push_back(DATA);
            got_addr.push_back(ADDR);
            lat = $time - fall_t;
        end
        if (FRAME_DONE === 1'b1) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        got_data.delete();
        got_addr.delete();
        exp_q.delete();
        fd_cnt = 0;
    endtask

    task automatic send_bit_t(input logic b, input int hi_ns, input int lo_ns);
        DIN = 1'b1;
        #(hi_ns);
        DIN = 1'b0;
        fall_t = $time;
        #(lo_ns);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_bit_t(b, 800, 450);
        else   send_bit_t(b, 400, 850);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic low_us(input int us);
        DIN = 1'b0;
        #(us * 1000);
    endtask

    // Expected frame result: first min(n,NUM) words in order, addresses 0..
    task automatic check_frame(input string tag, input int n_sent, input logic exp_err);
        int n_exp;
        n_exp = (n_sent > NUM) ? NUM : n_sent;
        check({tag, "_nvalid"}, got_data.size(), n_exp);
        for (int i = 0; i < n_exp && i < got_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_q[i]);
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], i);
        end
        check({tag, "_fd"}, fd_cnt, 1);
        check({tag, "_ledcnt"}, LED_COUNT, n_exp);
        check({tag, "_err"}, ERR, exp_err);
    endtask

    initial begin
        logic [23:0] w;
        logic [3:0]  lc_prev;
        RST_N = 1'b0;
        DIN   = 1'b0;
        #53;
        check("rst_data", DATA, 0);
        check("rst_addr", ADDR, 0);
        check("rst_valid", VALID, 0);
        check("rst_fd", FRAME_DONE, 0);
        check("rst_ledcnt", LED_COUNT, 0);
        check("rst_err", ERR, 0);
        RST_N = 1'b1;
        low_us(60);

        // Single known word and fall-to-VALID latency.
        clr();
        exp_q.push_back(24'hA5C33C);
        send_word(24'hA5C33C);
        low_us(55);
        check_frame("t1", 1, 1'b0);
        check("t1_lat_window", ((lat > 60) && (lat <= 80)) ? 1 : 0, 1);

        // Overflow: 10 random words into 8 slots.
        clr();
        for (int i = 0; i < 10; i++) begin
            w = 24'($urandom);
            exp_q.push_back(w);
            send_word(w);
        end
        low_us(55);
        check_frame("t2", 10, 1'b1);
        clr();
        w = 24'($urandom);
        exp_q.push_back(w);
        send_word(w);
        check("t2_err_cleared", ERR, 0);
        low_us(55);
        check_frame("t2b", 1, 1'b0);

        // Partial word: 12 bits only.
        clr();
        w = 24'($urandom);
        for (int i = 23; i >= 12; i--) send_bit(w[i]);
        low_us(55);
        check("t3_nvalid", got_data.size(), 0);
        check("t3_fd", fd_cnt, 1);
        check("t3_ledcnt", LED_COUNT, 0);
        check("t3_err", ERR, 1);

        // Glitch mid-word aborts the frame; emitted word stands.
        clr();
        w = 24'($urandom);
        exp_q.push_back(w);
        send_word(w);
        w = 24'($urandom);
        for (int i = 23; i >= 19; i--) send_bit(w[i]);
        send_bit_t(1'b0, 60, 800);
        for (int i = 18; i >= 0; i--) send_bit(w[i]);
        send_word(24'($urandom));
        low_us(55);
        check("t4_nvalid", got_data.size(), 1);
        if (got_data.size() > 0) check("t4_data0", got_data[0], exp_q[0]);
        check("t4_fd", fd_cnt, 0);
        check("t4_ledcnt_held", LED_COUNT, 0);
        check("t4_err", ERR, 1);
        clr();
        for (int i = 0; i < 2; i++) begin
            w = 24'($urandom);
            exp_q.push_back(w);
            send_word(w);
        end
        low_us(55);
        check_frame("t4b", 2, 1'b0);

        // Reset released mid-frame: rest of frame ignored.
        send_word(24'($urandom));
        RST_N = 1'b0;
        #100;
        RST_N = 1'b1;
        check("t5_ledcnt_rst", LED_COUNT, 0);
        check("t5_err_rst", ERR, 0);
        clr();
        send_word(24'($urandom));
        send_word(24'($urandom));
        low_us(55);
        check("t5_nvalid", got_data.size(), 0);
        check("t5_fd", fd_cnt, 0);
        clr();
        w = 24'($urandom);
        exp_q.push_back(w);
        send_word(w);
        low_us(55);
        check_frame("t5b", 1, 1'b0);

        // Threshold sweep: 600 ns decodes 0, 660 ns decodes 1.
        clr();
        w = 24'($urandom);
        exp_q.push_back(w);
        for (int i = 23; i >= 0; i--) begin
            if (w[i]) send_bit_t(1'b1, 660, 600);
            else      send_bit_t(1'b0, 600, 600);
        end
        low_us(55);
        check_frame("t6", 1, 1'b0);

        // Stuck-high line aborts without FRAME_DONE; LED_COUNT held.
        clr();
        lc_prev = LED_COUNT;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit_t(1'b1, 2200, 450);
        low_us(55);
        check("t7_nvalid", got_data.size(), 0);
        check("t7_fd", fd_cnt, 0);
        check("t7_ledcnt_held", LED_COUNT, lc_prev);
        check("t7_err", ERR, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
